// File: rtl/max_seq_pkg.sv
// Shared types for the frame-maximum sequencer: FSM state encoding and index width.
package max_seq_pkg;
  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/max2_cmp.sv
// Purpose: picks the greater of two unsigned values and flags b > a.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module max2_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] max,
  output logic         b_gt_a
);
  // Strict compare: equal values keep a, so the earlier sample wins a tie.
  assign b_gt_a = (b > a);
  assign max    = b_gt_a ? b : a;
endmodule

// File: rtl/max_seq_ctrl.sv
// Purpose: finds the maximum (and optionally its index, MAX_SEQ_INDEX_EN) over an N-sample frame.
// Latency: result valid one cycle after the Nth accepted sample.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
module max_seq_ctrl
  import max_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_max,
`ifdef MAX_SEQ_INDEX_EN
  output logic [IDX_W-1:0] out_idx,
`endif
  output logic             busy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] count_q;
  logic [W-1:0]     max_q;
  logic [W-1:0]     cmp_max;
  logic             cmp_gt;
  logic             accept;
  logic             last_accept;
  logic             out_fire;
`ifdef MAX_SEQ_INDEX_EN
  logic [IDX_W-1:0] idx_q;
`endif

  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (count_q == LAST);
  assign out_fire    = out_valid & out_ready;

  max2_cmp #(.W(W)) u_cmp (
    .a      (max_q),
    .b      (in_data),
    .max    (cmp_max),
    .b_gt_a (cmp_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)       state_d = ACCUM;
      ACCUM:   if (last_accept) state_d = DONE;
      DONE:    if (out_fire)    state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // The first sample of a frame loads unconditionally so stale max never leaks in.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      max_q   <= '0;
`ifdef MAX_SEQ_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      if ((state_q == IDLE) && start) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + 1'b1;
        if ((count_q == '0) || cmp_gt) begin
          max_q <= (count_q == '0) ? in_data : cmp_max;
`ifdef MAX_SEQ_INDEX_EN
          idx_q <= count_q;
`endif
        end
      end
    end
  end

  assign out_max = max_q;
`ifdef MAX_SEQ_INDEX_EN
  assign out_idx = idx_q;
`endif
endmodule

// File: tb/tb_max_seq_ctrl.sv
// Scoreboard bench for max_seq_ctrl: directed frames push expected results, a monitor
// pops and compares on every output handshake. Works with or without MAX_SEQ_INDEX_EN.
module tb_max_seq_ctrl;
  localparam int W = 8;
  localparam int N = 8;

  typedef struct {
    int mx;
    int ix;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_max;
  logic         busy;
`ifdef MAX_SEQ_INDEX_EN
  logic [7:0]   out_idx;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   fr[8];

  always #5 clk = ~clk;

  max_seq_ctrl #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
`ifdef MAX_SEQ_INDEX_EN
    .out_idx   (out_idx),
`endif
    .busy      (busy)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out_max %0d, expected no result", out_max);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_max", int'(out_max), e.mx);
`ifdef MAX_SEQ_INDEX_EN
        check("result_idx", int'(out_idx), e.ix);
`endif
      end
    end
  end

  task automatic push_exp(input int mx, input int ix);
    exp_t e;
    e.mx = mx;
    e.ix = ix;
    exp_q.push_back(e);
  endtask

  task automatic begin_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Send fr[lo..hi-1]; when the frame completes, out_valid must rise next cycle.
  task automatic send(input int lo, input int hi, input bit gaps);
    for (int i = lo; i < hi; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = W'(fr[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
    end
    if (hi == N) begin
      @(negedge clk);
      check("out_valid_latency", int'(out_valid), 1);
    end
  endtask

  task automatic set_frame(input int a0, input int a1, input int a2, input int a3,
                           input int a4, input int a5, input int a6, input int a7);
    fr[0] = a0; fr[1] = a1; fr[2] = a2; fr[3] = a3;
    fr[4] = a4; fr[5] = a5; fr[6] = a6; fr[7] = a7;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_out_max"},   int'(out_max),   0);
`ifdef MAX_SEQ_INDEX_EN
    check({tag, "_out_idx"},   int'(out_idx),   0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Tie on 9 keeps index 1.
    begin_frame();
    @(negedge clk);
    check("accum_busy", int'(busy), 1);
    check("accum_in_ready", int'(in_ready), 1);
    set_frame(3, 9, 2, 9, 1, 0, 4, 7);
    push_exp(9, 1);
    send(0, 8, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_frame_busy", int'(busy), 0);

    begin_frame();
    set_frame(0, 0, 0, 0, 0, 0, 0, 0);
    push_exp(0, 0);
    send(0, 8, 1'b0);

    begin_frame();
    set_frame(0, 1, 2, 3, 4, 5, 6, 7);
    push_exp(7, 7);
    send(0, 8, 1'b0);

    // in_valid while IDLE must be ignored; next frame must show no trace of 200.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'd200;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", int'(in_ready), 0);
      check("idle_busy", int'(busy), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    begin_frame();
    set_frame(1, 4, 4, 2, 0, 3, 3, 1);
    push_exp(4, 1);
    send(0, 8, 1'b0);

    // start during ACCUM ignored, random gaps, out_ready low 5 cycles with start in DONE.
    begin_frame();
    set_frame(6, 2, 8, 8, 3, 1, 0, 5);
    push_exp(8, 2);
    send(0, 4, 1'b1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_in_accum_in_ready", int'(in_ready), 1);
    send(4, 7, 1'b1);
    out_ready = 1'b0;
    send(7, 8, 1'b1);
    #1 start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_max", int'(out_max), 8);
      check("hold_busy", int'(busy), 1);
      start = 1'b0;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("after_handshake_busy", int'(busy), 0);
    check("after_handshake_out_valid", int'(out_valid), 0);

    // Reset mid-frame after 4 large samples, then a clean ascending frame.
    begin_frame();
    set_frame(250, 251, 252, 253, 0, 0, 0, 0);
    send(0, 4, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_state("midframe_reset");
    @(posedge clk); #1 rst = 1'b0;
    begin_frame();
    set_frame(1, 2, 3, 4, 5, 6, 7, 8);
    push_exp(8, 7);
    send(0, 8, 1'b0);

    // Drain: every pushed result must have been observed within a bounded wait.
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/max_seq_ctrl.md
MAX_SEQ_CTRL -- requirements
Module: max_seq_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the sample data width in bits.
REQ-002 The block SHALL have parameter N, default 8, giving the number of samples per frame (legal range 2..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a frame.
REQ-006 in_valid  input  1  SHALL qualify in_data.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a sample this cycle.
REQ-008 in_data  input  W  SHALL carry an unsigned sample.
REQ-009 out_valid  output  1  SHALL indicate that the frame result is valid.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-011 out_max  output  W  SHALL carry the maximum sample of the frame.
REQ-012 out_idx  output  8  SHALL carry the 0-based position of that maximum; this port is present only when MAX_SEQ_INDEX_EN is defined.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, ACCUM and DONE.
REQ-015 In IDLE, in_ready and out_valid SHALL be 0; start=1 SHALL move the block to ACCUM on the next edge and clear the sample count.
REQ-016 In ACCUM, in_ready SHALL be 1; a sample is accepted only when in_valid and in_ready are both 1.
REQ-017 On acceptance with count=0, the block SHALL load max with in_data (and idx with 0).
REQ-018 On acceptance with count>0, max SHALL become in_data only if in_data > max (strict unsigned compare); on a tie the earlier index SHALL be kept.
REQ-019 Each acceptance SHALL increment count; acceptance of the Nth sample SHALL move the block to DONE on the same edge.
REQ-020 out_valid SHALL be 1 in the cycle immediately after the Nth acceptance (latency 1 cycle from the final handshake).
REQ-021 In DONE, out_max and out_idx SHALL hold stable until out_valid and out_ready are both 1; that handshake SHALL return the block to IDLE.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 in_valid SHALL be ignored outside ACCUM, and sample stalls (in_valid=0) SHALL NOT alter state.
REQ-024 Wait cycles in ACCUM SHALL be unbounded; there is no timeout.

Reset
REQ-025 rst=1 SHALL force IDLE, count=0, max=0, idx=0, in_ready=0, out_valid=0 and busy=0 at the next edge.
REQ-026 Reset asserted mid-frame SHALL discard all partial results; rst SHALL take priority over start and over both handshakes.

Configuration
REQ-027 With MAX_SEQ_INDEX_EN defined, the block SHALL track the index register and drive the out_idx port.
REQ-028 Without MAX_SEQ_INDEX_EN, the out_idx port and the index register SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package max_seq_pkg SHALL hold the state enum typedef (IDLE/ACCUM/DONE) and the index width constant (8).
REQ-030 The compare SHALL be a sub-module max2_cmp: purely combinational, returning the greater of two W-bit values and a flag for "b > a".

Verification
REQ-031 Frame 3,9,2,9,1,0,4,7 with no stalls SHALL produce out_max=9 and out_idx=1 (tie keeps the earlier index), with out_valid high one cycle after the 8th acceptance.
REQ-032 All-zero frame SHALL produce out_max=0 and out_idx=0; frame 0..7 ascending SHALL produce out_max=7 and out_idx=7.
REQ-033 Random in_valid gaps plus out_ready held low for 5 cycles SHALL keep out_max stable and return the block to IDLE only after the out_ready handshake.
REQ-034 start pulsed during ACCUM and DONE SHALL cause no state change; in_valid asserted in IDLE SHALL accept no sample.
REQ-035 rst asserted after 4 samples, followed by a new frame 1,2,...,8, SHALL produce out_max=8 and out_idx=7 with no residue from the first frame.
REQ-036 A build without MAX_SEQ_INDEX_EN running the REQ-031 stimulus SHALL produce out_max=9.
